mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port synchronous memory between the cpu data port (requester 0) and the program loader / debug port (requester 1). It sits between `cpu` (aluout/writedata/memwrite/readdata side) and the data memory. Requests are captured with a valid/ready handshake. Fairness is round-robin with a registered grant. Reads return through a per-requester response pulse after fixed latency.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 80 ++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester, response and memory-side signals shared by mem_arbiter and its environment.
// master = requesters plus memory model, slave = the arbiter.
`ifndef WORD
`define WORD 32
`endif

interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = `WORD
);
    logic          req0_valid;
    logic          req1_valid;
    logic          req0_we;
    logic          req1_we;
    logic [AW-1:0] req0_addr;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req0_wdata;
    logic [DW-1:0] req1_wdata;
    logic          req0_ready;
    logic          req1_ready;
    logic          resp0_valid;
    logic          resp1_valid;
    logic [DW-1:0] resp_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport master (
        output req0_valid, req1_valid, req0_we, req1_we,
        output req0_addr, req1_addr, req0_wdata, req1_wdata,
        output mem_rdata,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_we, req1_we,
        input  req0_addr, req1_addr, req0_wdata, req1_wdata,
        input  mem_rdata,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between two requesters.
// One transaction in flight: IDLE accepts, ISSUE strobes memory, RESP returns read data.
`ifndef WORD
`define WORD 32
`endif

module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = `WORD
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_q;
    logic          grant_q;
    logic          last_grant_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;

    logic win0, win1, hs0, hs1, issue, resp;

    always_comb begin
        win0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        win1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end

    // Reset gates every output combinationally so an abandoned ISSUE never writes.
    assign bus.req0_ready = (state_q == IDLE) && !reset && win0;
    assign bus.req1_ready = (state_q == IDLE) && !reset && win1;
    assign hs0 = bus.req0_valid && bus.req0_ready;
    assign hs1 = bus.req1_valid && bus.req1_ready;

    assign issue = (state_q == ISSUE) && !reset;
    assign resp  = (state_q == RESP) && !reset;

    assign bus.mem_en      = issue;
    assign bus.mem_we      = issue && we_q;
    assign bus.mem_addr    = issue ? addr_q : '0;
    assign bus.mem_wdata   = issue ? wdata_q : '0;
    assign bus.resp0_valid = resp && !grant_q;
    assign bus.resp1_valid = resp && grant_q;
    assign bus.resp_rdata  = reset ? '0 : (resp ? bus.mem_rdata : rdata_q);
    assign bus.busy        = (state_q != IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs0 || hs1) begin
                        grant_q      <= hs1;
                        last_grant_q <= hs1;
                        we_q         <= hs1 ? bus.req1_we    : bus.req0_we;
                        addr_q       <= hs1 ? bus.req1_addr  : bus.req0_addr;
                        wdata_q      <= hs1 ? bus.req1_wdata : bus.req0_wdata;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: state_q <= we_q ? IDLE : RESP;
                RESP: begin
                    rdata_q <= bus.mem_rdata;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// a directed vector table, hand-written corner sequences and a randomized run.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE0000 ^ (i * 32'h00010101);
    endfunction

    // Environment memory: one-cycle read latency, word index from addr[9:2].
    logic [31:0] env_mem [256];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) env_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= env_mem[bus.mem_addr[9:2]];
        end
    end

    // Reference model: m_t counts cycles since the accepting handshake (0 = idle).
    logic [31:0] refmem [256];
    bit          model_on = 0;
    int          m_t = 0;
    bit          m_lastg = 1, m_gr = 0, m_we = 0;
    logic [31:0] m_addr = 0, m_wd = 0, m_rdata = 0;
    bit          hs0 = 0, hs1 = 0;
    int          cyc = 0;
    int          hs_cyc[$];
    bit          hs_who[$];
    logic [31:0] hs_addr[$];
    int          rsp_cyc[$];
    bit          rsp_who[$];
    logic [31:0] rsp_data[$];

    always @(negedge clk) begin : mdl
        bit e_r0, e_r1, e_en, e_we, e_p0, e_p1, e_busy, w;
        logic [31:0] e_addr, e_wd, e_rd;
        if (model_on) begin
            {e_r0, e_r1, e_en, e_we, e_p0, e_p1, e_busy} = '0;
            e_addr = 0; e_wd = 0; e_rd = m_rdata;
            if (reset) begin
                e_rd = 0; m_t = 0; m_lastg = 1; m_rdata = 0;
            end else if (m_t == 0) begin
                if (bus.req0_valid || bus.req1_valid) begin
                    if (bus.req0_valid && bus.req1_valid) w = !m_lastg;
                    else w = bus.req1_valid;
                    e_r0 = !w; e_r1 = w;
                    m_gr = w; m_lastg = w;
                    m_we   = w ? bus.req1_we    : bus.req0_we;
                    m_addr = w ? bus.req1_addr  : bus.req0_addr;
                    m_wd   = w ? bus.req1_wdata : bus.req0_wdata;
                    m_t = 1;
                end
            end else if (m_t == 1) begin
                e_en = 1; e_we = m_we; e_addr = m_addr; e_wd = m_wd; e_busy = 1;
                if (m_we) begin
                    refmem[m_addr[9:2]] = m_wd;
                    m_t = 0;
                end else m_t = 2;
            end else begin
                e_busy = 1; e_p0 = !m_gr; e_p1 = m_gr;
                e_rd = refmem[m_addr[9:2]];
                m_rdata = e_rd; m_t = 0;
            end
            chk("req0_ready",  bus.req0_ready,  e_r0);
            chk("req1_ready",  bus.req1_ready,  e_r1);
            chk("mem_en",      bus.mem_en,      e_en);
            chk("mem_we",      bus.mem_we,      e_we);
            chk("mem_addr",    bus.mem_addr,    e_addr);
            chk("mem_wdata",   bus.mem_wdata,   e_wd);
            chk("resp0_valid", bus.resp0_valid, e_p0);
            chk("resp1_valid", bus.resp1_valid, e_p1);
            chk("resp_rdata",  bus.resp_rdata,  e_rd);
            chk("busy",        bus.busy,        e_busy);
            hs0 = bus.req0_valid && bus.req0_ready;
            hs1 = bus.req1_valid && bus.req1_ready;
            if (hs0 || hs1) begin
                hs_cyc.push_back(cyc);
                hs_who.push_back(hs1);
                hs_addr.push_back(hs1 ? bus.req1_addr : bus.req0_addr);
            end
            if (bus.resp0_valid || bus.resp1_valid) begin
                rsp_cyc.push_back(cyc);
                rsp_who.push_back(bus.resp1_valid);
                rsp_data.push_back(bus.resp_rdata);
            end
        end
        cyc++;
    end

    task automatic run_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (m_t != 0 && n < budget) begin
            run_cycle();
            n++;
        end
        chk("wait_idle_timeout", m_t, 0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } item_t;
    item_t q0[$], q1[$];

    task automatic present(input bit gaps);
        if (!bus.req0_valid && q0.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
            bus.req0_valid = 1; bus.req0_we = q0[0].we;
            bus.req0_addr = q0[0].addr; bus.req0_wdata = q0[0].wd;
        end
        if (!bus.req1_valid && q1.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
            bus.req1_valid = 1; bus.req1_we = q1[0].we;
            bus.req1_addr = q1[0].addr; bus.req1_wdata = q1[0].wd;
        end
    endtask

    // Requesters hold each request until accepted, then present the next one.
    task automatic run_queues(input int budget, input bit gaps);
        int n = 0;
        bit done = 0;
        present(gaps);
        while (!done && n < budget) begin
            run_cycle();
            n++;
            if (hs0) begin void'(q0.pop_front()); bus.req0_valid = 0; end
            if (hs1) begin void'(q1.pop_front()); bus.req1_valid = 0; end
            present(gaps);
            done = (q0.size() == 0) && (q1.size() == 0) && !bus.req0_valid
                   && !bus.req1_valid && (m_t == 0);
        end
        chk("run_queues_timeout", done, 1);
    endtask

    typedef struct {
        logic        v0, v1, we0, we1;
        logic [31:0] a0, a1;
        logic        e0, e1;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int b, rb, n;
        bit prev;
        tbl[0] = '{1, 1, 0, 0, 32'h00, 32'h04, 1, 0};
        tbl[1] = '{1, 1, 1, 0, 32'h08, 32'h0C, 0, 1};
        tbl[2] = '{0, 1, 0, 1, 32'h00, 32'h14, 0, 1};
        tbl[3] = '{1, 1, 1, 0, 32'h18, 32'h1C, 1, 0};
        tbl[4] = '{1, 0, 0, 0, 32'h18, 32'h00, 1, 0};
        tbl[5] = '{1, 1, 0, 1, 32'h20, 32'h24, 0, 1};
        tbl[6] = '{0, 0, 0, 0, 32'h00, 32'h00, 0, 0};
        tbl[7] = '{1, 1, 0, 0, 32'h24, 32'h28, 1, 0};
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = pat(i);
            refmem[i]  = pat(i);
        end
        bus.req0_valid = 1; bus.req1_valid = 1;
        bus.req0_we = 0; bus.req1_we = 0;
        bus.req0_addr = 0; bus.req1_addr = 32'h04;
        bus.req0_wdata = 0; bus.req1_wdata = 0;
        @(posedge clk); #1;
        model_on = 1;

        // Reset held two cycles with both requesters asking, then the vector table.
        run_cycle();
        run_cycle();
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            bus.req0_valid = tbl[i].v0; bus.req1_valid = tbl[i].v1;
            bus.req0_we = tbl[i].we0;   bus.req1_we = tbl[i].we1;
            bus.req0_addr = tbl[i].a0;  bus.req1_addr = tbl[i].a1;
            bus.req0_wdata = 32'hA0000000 | i; bus.req1_wdata = 32'hB0000000 | i;
            run_cycle();
            chk($sformatf("tbl%0d_hs0", i), hs0, tbl[i].e0);
            chk($sformatf("tbl%0d_hs1", i), hs1, tbl[i].e1);
            bus.req0_valid = 0; bus.req1_valid = 0;
            wait_idle(10);
        end

        // Write then read back through requester 0.
        b = hs_cyc.size(); rb = rsp_cyc.size();
        q0.push_back('{1, 32'h40, 32'hDEADBEEF});
        q0.push_back('{0, 32'h40, 32'h0});
        run_queues(30, 0);
        chk("wr_rd_hs_count", hs_cyc.size() - b, 2);
        chk("wr_rd_rsp_count", rsp_cyc.size() - rb, 1);
        if (hs_cyc.size() - b == 2 && rsp_cyc.size() - rb == 1) begin
            chk("wr_spacing", hs_cyc[b+1] - hs_cyc[b], 2);
            chk("rd_latency", rsp_cyc[rb] - hs_cyc[b+1], 2);
            chk("rd_who", rsp_who[rb], 0);
            chk("rd_data", rsp_data[rb], 32'hDEADBEEF);
        end

        // Both requesters stream reads: strict alternation at 3-cycle spacing.
        b = hs_cyc.size(); rb = rsp_cyc.size(); prev = hs_who[b-1];
        for (int k = 0; k < 4; k++) begin
            q0.push_back('{0, 32'h100 + 4*k, 32'h0});
            q1.push_back('{0, 32'h200 + 4*k, 32'h0});
        end
        run_queues(60, 0);
        chk("rr_hs_count", hs_cyc.size() - b, 8);
        chk("rr_rsp_count", rsp_cyc.size() - rb, 8);
        if (hs_cyc.size() - b == 8 && rsp_cyc.size() - rb == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("rr_who%0d", k), hs_who[b+k], !prev);
                prev = hs_who[b+k];
                if (k > 0) chk($sformatf("rr_spacing%0d", k), hs_cyc[b+k] - hs_cyc[b+k-1], 3);
                chk($sformatf("rr_rsp_who%0d", k), rsp_who[rb+k], hs_who[b+k]);
                chk($sformatf("rr_rsp_data%0d", k), rsp_data[rb+k], pat(int'(hs_addr[b+k][9:2])));
            end
        end

        // Lone requester 1 streak of writes.
        b = hs_cyc.size();
        for (int k = 0; k < 4; k++) q1.push_back('{1, 32'h300 + 4*k, 32'h51000000 + k});
        run_queues(30, 0);
        chk("streak_hs_count", hs_cyc.size() - b, 4);
        if (hs_cyc.size() - b == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("streak_who%0d", k), hs_who[b+k], 1);
                if (k > 0) chk($sformatf("streak_spacing%0d", k), hs_cyc[b+k] - hs_cyc[b+k-1], 2);
            end
        end

        // Reset lands in the ISSUE cycle of a requester-1 read.
        bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 32'h80;
        run_cycle();
        chk("rst_mid_hs1", hs1, 1);
        bus.req1_valid = 0;
        rb = rsp_cyc.size();
        reset = 1;
        run_cycle();
        reset = 0;
        for (int k = 0; k < 5; k++) run_cycle();
        chk("rst_mid_no_resp", rsp_cyc.size() - rb, 0);
        chk("rst_mid_idle", bus.busy, 0);
        bus.req0_valid = 1; bus.req0_we = 0; bus.req0_addr = 32'h84;
        bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 32'h88;
        run_cycle();
        chk("rst_tie_hs0", hs0, 1);
        chk("rst_tie_hs1", hs1, 0);
        bus.req0_valid = 0; bus.req1_valid = 0;
        wait_idle(10);

        // Requester 1 write held while requester 0's read is in flight.
        b = hs_cyc.size();
        bus.req0_valid = 1; bus.req0_we = 0; bus.req0_addr = 32'h40;
        run_cycle();
        chk("bp_hs0", hs0, 1);
        bus.req0_valid = 0;
        bus.req1_valid = 1; bus.req1_we = 1; bus.req1_addr = 32'h10; bus.req1_wdata = 32'h600DF00D;
        n = 0;
        while (!hs1 && n < 10) begin
            run_cycle();
            n++;
        end
        chk("bp_hs1", hs1, 1);
        bus.req1_valid = 0;
        wait_idle(10);
        run_cycle();
        chk("bp_hs_count", hs_cyc.size() - b, 2);
        if (hs_cyc.size() - b == 2) chk("bp_spacing", hs_cyc[b+1] - hs_cyc[b], 3);
        chk("bp_landed", env_mem[4], 32'h600DF00D);

        // Randomized traffic with idle gaps, checked by the per-cycle model.
        for (int k = 0; k < 40; k++) begin
            q0.push_back('{1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, $urandom});
            q1.push_back('{1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, $urandom});
        end
        run_queues(2000, 1);
        for (int i = 0; i < 256; i++) begin
            if (env_mem[i] !== refmem[i]) chk($sformatf("final_mem%0d", i), env_mem[i], refmem[i]);
        end
        chk("final_mem_checked", 1, 1 && (env_mem[0] === refmem[0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
